lab3_serial_cla_adder: RTL and testbench

Nibble-serial wide adder that drives a single `Lab2_4_bit_CLA` slice. It accepts a W-bit operand pair through a start/done handshake and feeds the CLA one 4-bit nibble per clock, LSB first. It registers each sum nibble and chains the nibble carry through a flip-flop. It sits directly upstream of the CLA as its operand sequencer and directly downstream as its result collector.

---
 rtl/lab3_serial_cla_adder.sv | 164 ++++++++++++++++
 tb/tb_lab3_serial_cla_adder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_serial_cla_adder.sv
// rtl/lab3_serial_cla_adder.sv - nibble-serial wide adder sequencing one 4-bit CLA slice
// Optional subtract mode enabled by defining LAB3_SERIAL_SUB_EN.

module Lab2_4_bit_CLA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded from cin so no carry waits on its neighbour
    assign cc[0] = cin;
    assign cc[1] = g[0] | (p[0] & cin);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cin);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ cc[3:0];
    assign cout = cc[4];

endmodule

module lab3_serial_cla_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef LAB3_SERIAL_SUB_EN
    input  logic                 sub,
`endif
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          c;
    logic [W-1:0]  rs;

    logic [W-1:0]  eff_b;
    logic          eff_c;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    cla_s;
    logic          cla_c;
    logic [W-1:0]  next_rs;
    logic          last;

`ifdef LAB3_SERIAL_SUB_EN
    // A - B is formed as A + ~B + 1, so the operand carry is forced high
    assign eff_b = sub ? ~b : b;
    assign eff_c = sub ? 1'b1 : cin;
`else
    assign eff_b = b;
    assign eff_c = cin;
`endif

    assign last = (cnt == CW'(NIBBLES - 1));

    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == i[CW-1:0]) begin
                nib_a = ra[4*i +: 4];
                nib_b = rb[4*i +: 4];
            end
        end
    end

    Lab2_4_bit_CLA u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (c),
        .s    (cla_s),
        .cout (cla_c)
    );

    // Partial result with the current nibble merged in; on the last nibble this is the final sum
    always_comb begin
        next_rs = rs;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == i[CW-1:0]) begin
                next_rs[4*i +: 4] = cla_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            c     <= 1'b0;
            rs    <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= eff_b;
                        c     <= eff_c;
                        cnt   <= '0;
                        rs    <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rs <= next_rs;
                    c  <= cla_c;
                    if (last) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= next_rs;
                        cout  <= cla_c;
                        ovf   <= (ra[W-1] == rb[W-1]) && (next_rs[W-1] != ra[W-1]);
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_serial_cla_adder.sv
// tb/tb_lab3_serial_cla_adder.sv - randomized self-checking bench for lab3_serial_cla_adder

module tb_lab3_serial_cla_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic        done;

    logic        s_start;
    logic [3:0]  s_a;
    logic [3:0]  s_b;
    logic        s_cin;
    logic [3:0]  s_sum;
    logic        s_cout;
    logic        s_ovf;
    logic        s_busy;
    logic        s_done;

`ifdef LAB3_SERIAL_SUB_EN
    logic        sub;
    logic        s_sub;
`endif

    int checks;
    int fails;

    lab3_serial_cla_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef LAB3_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    lab3_serial_cla_adder #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (s_start),
        .a     (s_a),
        .b     (s_b),
        .cin   (s_cin),
`ifdef LAB3_SERIAL_SUB_EN
        .sub   (s_sub),
`endif
        .sum   (s_sum),
        .cout  (s_cout),
        .ovf   (s_ovf),
        .busy  (s_busy),
        .done  (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain integer arithmetic on the effective operands
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] eb;
        logic [16:0] r;
        logic        o;
        eb = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, eb} + 17'(sb ? 1'b1 : ci);
        o  = (x[15] == eb[15]) && (r[15] != x[15]);
        return {o, r[16], r[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic sb, output logic [15:0] rsum, output logic rc,
                          output logic ro, output int cyc, output int bcnt);
        a   = x;
        b   = y;
        cin = ci;
`ifdef LAB3_SERIAL_SUB_EN
        sub = sb;
`else
        if (sb) $display("note: sub requested without subtract build");
`endif
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        cyc  = 1;
        bcnt = 0;
        while (cyc <= 20 && done !== 1'b1) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        rsum = sum;
        rc   = cout;
        ro   = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({sum, cout, ovf, busy, done} !== 20'd0) begin
            fails++;
            $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     sum, cout, ovf, busy, done);
        end
        checks++;
        if ({s_sum, s_cout, s_ovf, s_busy, s_done} !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs_n1: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     s_sum, s_cout, s_ovf, s_busy, s_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] rsum;
        logic        rc, ro;
        int          cyc, bcnt;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, rsum, rc, ro, cyc, bcnt);
        checks++;
        if (cyc != 5) begin
            fails++;
            $display("FAIL basic_latency: done in cycle %0d, want 5", cyc);
        end
        checks++;
        if (bcnt != 4) begin
            fails++;
            $display("FAIL basic_busy_cycles: busy %0d cycles, want 4", bcnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_at_done: busy=%b, want 0", busy);
        end
        checks++;
        if ({ro, rc, rsum} !== {1'b0, 1'b0, 16'h5555}) begin
            fails++;
            $display("FAIL basic_result: got sum=%h cout=%b ovf=%b, want 5555 0 0", rsum, rc, ro);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sum !== 16'h5555) begin
            fails++;
            $display("FAIL basic_pulse_hold: done=%b sum=%h, want done 0 sum 5555", done, sum);
        end
    endtask

    task automatic test_carry_ripple();
        logic [15:0] rsum;
        logic        rc, ro;
        int          cyc, bcnt;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rsum, rc, ro, cyc, bcnt);
        checks++;
        if ({ro, rc, rsum} !== {1'b0, 1'b1, 16'h0000} || cyc != 5) begin
            fails++;
            $display("FAIL carry_ripple: got sum=%h cout=%b ovf=%b cyc=%0d, want 0000 1 0 cyc 5",
                     rsum, rc, ro, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] rsum;
        logic        rc, ro;
        int          cyc, bcnt;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rsum, rc, ro, cyc, bcnt);
        checks++;
        if ({ro, rc, rsum} !== {1'b1, 1'b0, 16'h8000}) begin
            fails++;
            $display("FAIL b2b_first: got sum=%h cout=%b ovf=%b, want 8000 0 1", rsum, rc, ro);
        end
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, rsum, rc, ro, cyc, bcnt);
        checks++;
        if ({ro, rc, rsum} !== {1'b1, 1'b1, 16'h0001} || cyc != 5) begin
            fails++;
            $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b cyc=%0d, want 0001 1 1 cyc 5",
                     rsum, rc, ro, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int cyc;
        int extra;
        a = 16'h0102;
        b = 16'h0304;
        cin = 1'b0;
`ifdef LAB3_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (sum !== 16'h0001) begin
            fails++;
            $display("FAIL sum_held_on_start: got %h, want 0001", sum);
        end
        cyc = 1;
        while (cyc <= 20 && done !== 1'b1) begin
            if (cyc == 2) begin
                start = 1'b1;
                a = 16'hFFFF;
                b = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (sum !== 16'h0406 || cout !== 1'b0 || cyc != 5) begin
            fails++;
            $display("FAIL ignore_start_result: got sum=%h cout=%b cyc=%0d, want 0406 0 cyc 5",
                     sum, cout, cyc);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            fails++;
            $display("FAIL ignore_start_queued: %0d busy/done cycles after, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rsum;
        logic        rc, ro;
        int          cyc, bcnt;
        int          seen;
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sum, cout, ovf, busy, done} !== 20'd0) begin
            fails++;
            $display("FAIL reset_mid_run: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     sum, cout, ovf, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_abort: %0d busy/done cycles after release, want 0", seen);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, rsum, rc, ro, cyc, bcnt);
        checks++;
        if (rsum !== 16'h1000 || cyc != 5) begin
            fails++;
            $display("FAIL reset_recover: got sum=%h cyc=%0d, want 1000 cyc 5", rsum, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] x, y, rsum;
        logic        ci, sb, rc, ro;
        logic [17:0] exp;
        int          cyc, bcnt;
        for (int n = 0; n < 40; n++) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom);
`ifdef LAB3_SERIAL_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(x, y, ci, sb, rsum, rc, ro, cyc, bcnt);
            exp = model(x, y, ci, sb);
            checks++;
            if ({ro, rc, rsum} !== exp || cyc != 5 || bcnt != 4) begin
                fails++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got ovf/cout/sum=%b/%b/%h cyc=%0d, want %b/%b/%h cyc 5",
                         n, x, y, ci, sb, ro, rc, rsum, cyc, exp[17], exp[16], exp[15:0]);
            end
            if (n % 3 == 0) @(negedge clk);
        end
    endtask

`ifdef LAB3_SERIAL_SUB_EN
    task automatic test_sub();
        logic [15:0] rsum;
        logic        rc, ro;
        int          cyc, bcnt;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rsum, rc, ro, cyc, bcnt);
        checks++;
        if (rsum !== 16'hFFFE || rc !== 1'b0) begin
            fails++;
            $display("FAIL sub_borrow: got sum=%h cout=%b, want FFFE 0", rsum, rc);
        end
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, rsum, rc, ro, cyc, bcnt);
        checks++;
        if (rsum !== 16'h0002 || rc !== 1'b1) begin
            fails++;
            $display("FAIL sub_noborrow: got sum=%h cout=%b, want 0002 1", rsum, rc);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_sweep_n1();
        int cyc;
        int exp;
        logic exp_ovf;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    s_a = 4'(x);
                    s_b = 4'(y);
                    s_cin = 1'(ci);
                    s_start = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    s_start = 1'b0;
                    cyc = 1;
                    while (cyc <= 10 && s_done !== 1'b1) begin
                        @(negedge clk);
                        cyc++;
                    end
                    exp = x + y + ci;
                    exp_ovf = (x / 8 == y / 8) && (((exp % 16) / 8) != x / 8);
                    checks++;
                    if ({s_ovf, s_cout, s_sum} !== {exp_ovf, 5'(exp)} || cyc != 2) begin
                        fails++;
                        $display("FAIL sweep_n1: a=%0d b=%0d cin=%0d got ovf/cout/sum=%b/%b/%0d cyc=%0d, want %b/%0d cyc 2",
                                 x, y, ci, s_ovf, s_cout, s_sum, cyc, exp_ovf, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_cin   = 1'b0;
`ifdef LAB3_SERIAL_SUB_EN
        sub     = 1'b0;
        s_sub   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_carry_ripple();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
`ifdef LAB3_SERIAL_SUB_EN
        test_sub();
`endif
        test_sweep_n1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
